sobel_window_ctrl: RTL and testbench

//  Sequences a raster pixel stream into 3x3 neighbourhoods for the Sobel kernel datapath.

---
 rtl/sobel_pkg.sv | 16 +
 rtl/sobel_window_ctrl_if.sv | 38 +++
 rtl/sobel_line_buf.sv | 24 ++
 rtl/sobel_window_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel window controller slice.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    localparam int P_NUM_BITS_DEF = 8;
    localparam int IMG_W_DEF      = 640;
    localparam int IMG_H_DEF      = 480;
    localparam int COL_W_DEF      = $clog2(IMG_W_DEF);
    localparam int ROW_W_DEF      = $clog2(IMG_H_DEF);

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle; master is the stream source side, slave is the controller.
interface sobel_window_ctrl_if #(
    parameter int P_NUM_BITS = sobel_pkg::P_NUM_BITS_DEF,
    parameter int IMG_W      = sobel_pkg::IMG_W_DEF,
    parameter int IMG_H      = sobel_pkg::IMG_H_DEF
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic                  in_valid;
    logic                  in_ready;
    logic [P_NUM_BITS-1:0] in_pixel;
    logic                  in_sof;
    logic                  out_valid;
    logic                  out_ready;
    logic [P_NUM_BITS-1:0] out_x00, out_x01, out_x02;
    logic [P_NUM_BITS-1:0] out_x10, out_x11, out_x12;
    logic [P_NUM_BITS-1:0] out_x20, out_x21, out_x22;
    logic [ROW_W-1:0]      out_row;
    logic [COL_W-1:0]      out_col;
    logic                  frame_done;
    logic                  frame_err;

    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid,
        input  out_x00, out_x01, out_x02, out_x10, out_x11, out_x12, out_x20, out_x21, out_x22,
        input  out_row, out_col, frame_done, frame_err
    );

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid,
        output out_x00, out_x01, out_x02, out_x10, out_x11, out_x12, out_x20, out_x21, out_x22,
        output out_row, out_col, frame_done, frame_err
    );

endinterface

// File: rtl/sobel_line_buf.sv
// One line of pixel storage: synchronous write, asynchronous read, single shared address.
module sobel_line_buf #(
    parameter int P_NUM_BITS = 8,
    parameter int IMG_W      = 640,
    parameter int ADDR_W     = $clog2(IMG_W)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [P_NUM_BITS-1:0] wdata,
    output logic [P_NUM_BITS-1:0] rdata
);
    logic [P_NUM_BITS-1:0] mem_q [IMG_W];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Turns a raster pixel stream into 3x3 windows, one per interior pixel, with valid/ready flow control.
// Two line buffers hold the previous two rows; the tap registers form the sliding window.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int P_NUM_BITS = P_NUM_BITS_DEF,
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF
) (
    input logic                clk,
    input logic                reset,
    sobel_window_ctrl_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d, out_row_q, out_row_d;
    logic [COL_W-1:0]      col_q, col_d, out_col_q, out_col_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_err_q, frame_err_d;
    logic [P_NUM_BITS-1:0] tap_q [3][3];
    logic [P_NUM_BITS-1:0] tap_d [3][3];

    logic                  in_ready_s, accept_s, sof_acc_s, store_s, last_pix_s;
    logic [ROW_W-1:0]      pos_r_s;
    logic [COL_W-1:0]      pos_c_s;
    logic [P_NUM_BITS-1:0] lb0_rd_s, lb1_rd_s;

    // Handshake and the position of the pixel on the bus; an accepted in_sof always lands at (0,0).
    always_comb begin
        in_ready_s = !reset
                   && ((state_q != ST_IDLE) || bus.in_sof || bus.in_valid)
                   && (!out_valid_q || bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s;
        sof_acc_s  = accept_s && bus.in_sof;
        store_s    = accept_s && ((state_q != ST_IDLE) || bus.in_sof);
        pos_r_s    = sof_acc_s ? {ROW_W{1'b0}} : row_q;
        pos_c_s    = sof_acc_s ? {COL_W{1'b0}} : col_q;
        last_pix_s = (pos_r_s == ROW_W'(IMG_H - 1)) && (pos_c_s == COL_W'(IMG_W - 1));
    end

    sobel_line_buf #(.P_NUM_BITS(P_NUM_BITS), .IMG_W(IMG_W)) u_lb0 (
        .clk(clk), .we(store_s), .addr(pos_c_s), .wdata(bus.in_pixel), .rdata(lb0_rd_s)
    );

    sobel_line_buf #(.P_NUM_BITS(P_NUM_BITS), .IMG_W(IMG_W)) u_lb1 (
        .clk(clk), .we(store_s), .addr(pos_c_s), .wdata(lb0_rd_s), .rdata(lb1_rd_s)
    );

    // Next-state: window shift, counters, window emission and frame FSM.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        tap_d        = tap_q;
        if (store_s) begin
            for (int r = 0; r < 3; r++) begin
                tap_d[r][0] = tap_q[r][1];
                tap_d[r][1] = tap_q[r][2];
            end
            tap_d[0][2] = lb1_rd_s;
            tap_d[1][2] = lb0_rd_s;
            tap_d[2][2] = bus.in_pixel;

            if (pos_c_s == COL_W'(IMG_W - 1)) begin
                col_d = {COL_W{1'b0}};
                row_d = (pos_r_s == ROW_W'(IMG_H - 1)) ? {ROW_W{1'b0}} : pos_r_s + ROW_W'(1);
            end else begin
                col_d = pos_c_s + COL_W'(1);
                row_d = pos_r_s;
            end

            if ((pos_r_s >= ROW_W'(2)) && (pos_c_s >= COL_W'(2))) begin
                out_valid_d = 1'b1;
                out_row_d   = pos_r_s - ROW_W'(1);
                out_col_d   = pos_c_s - COL_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end

            if (sof_acc_s) begin
                state_d     = ST_FILL;
                frame_err_d = (state_q != ST_IDLE);
            end else begin
                case (state_q)
                    ST_FILL: begin
                        if ((pos_r_s == ROW_W'(2)) && (pos_c_s == COL_W'(2))) begin
                            state_d = ST_STREAM;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                    ST_STREAM: begin
                        if (last_pix_s) begin
                            state_d      = ST_IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ST_STREAM;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset discards any pending window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            row_q        <= {ROW_W{1'b0}};
            col_q        <= {COL_W{1'b0}};
            out_row_q    <= {ROW_W{1'b0}};
            out_col_q    <= {COL_W{1'b0}};
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    tap_q[r][c] <= {P_NUM_BITS{1'b0}};
                end
            end
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    tap_q[r][c] <= tap_d[r][c];
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.out_x00    = tap_q[0][0];
    assign bus.out_x01    = tap_q[0][1];
    assign bus.out_x02    = tap_q[0][2];
    assign bus.out_x10    = tap_q[1][0];
    assign bus.out_x11    = tap_q[1][1];
    assign bus.out_x12    = tap_q[1][2];
    assign bus.out_x20    = tap_q[2][0];
    assign bus.out_x21    = tap_q[2][1];
    assign bus.out_x22    = tap_q[2][2];

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 5x4 image: vector table plus image-array scoreboard.
module tb_sobel_window_ctrl;
    localparam int PW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic reset;

    sobel_window_ctrl_if #(.P_NUM_BITS(PW), .IMG_W(W), .IMG_H(H)) bus ();

    sobel_window_ctrl #(.P_NUM_BITS(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] taps;
        logic [1:0]  row;
        logic [2:0]  col;
    } win_t;

    typedef struct {
        logic       rst;
        logic       v;
        logic       s;
        logic [7:0] p;
        logic       rdy;
        logic       e_ir;
        logic       e_ov;
    } vec_t;

    vec_t       tbl [6];
    win_t       q   [$];
    win_t       got [$];
    logic [7:0] img [H][W];
    int         checks = 0, errors = 0;
    int         m_r = 0, m_c = 0;
    bit         m_active = 1'b0, exp_done = 1'b0, exp_err = 1'b0, rand_mode = 1'b0;
    int         done_seen = 0, err_seen = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] dut_taps();
        return {bus.out_x00, bus.out_x01, bus.out_x02,
                bus.out_x10, bus.out_x11, bus.out_x12,
                bus.out_x20, bus.out_x21, bus.out_x22};
    endfunction

    function automatic logic [7:0] pix(input int base, input int r, input int c);
        return 8'((base + r * W + c) & 255);
    endfunction

    // Golden model: keep the whole frame as an image and cut windows straight out of it.
    task automatic model_accept(input logic [7:0] p, input logic s);
        win_t w;
        if (s) begin
            exp_err  = m_active;
            m_active = 1'b1;
            m_r      = 0;
            m_c      = 0;
        end
        if (m_active) begin
            img[m_r][m_c] = p;
            if (m_r >= 2 && m_c >= 2) begin
                w.taps = {img[m_r-2][m_c-2], img[m_r-2][m_c-1], img[m_r-2][m_c],
                          img[m_r-1][m_c-2], img[m_r-1][m_c-1], img[m_r-1][m_c],
                          img[m_r][m_c-2],   img[m_r][m_c-1],   img[m_r][m_c]};
                w.row  = 2'(m_r - 1);
                w.col  = 3'(m_c - 1);
                q.push_back(w);
            end
            if (m_r == H - 1 && m_c == W - 1) begin
                exp_done = 1'b1;
                m_active = 1'b0;
            end
            if (m_c == W - 1) begin
                m_c = 0;
                m_r = (m_r == H - 1) ? 0 : m_r + 1;
            end else begin
                m_c = m_c + 1;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] p, input logic s, input logic rdy,
                         output logic acc);
        bit pend, exp_rdy;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_pixel  = p;
        bus.in_sof    = s;
        bus.out_ready = rdy;
        #1;
        pend = (q.size() != 0);
        chk("out_valid", 72'(bus.out_valid), 72'(pend));
        chk("frame_done", 72'(bus.frame_done), 72'(exp_done));
        chk("frame_err", 72'(bus.frame_err), 72'(exp_err));
        if (bus.frame_done) done_seen++;
        if (bus.frame_err) err_seen++;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (pend) begin
            chk("window_taps", dut_taps(), q[0].taps);
            chk("window_row", 72'(bus.out_row), 72'(q[0].row));
            chk("window_col", 72'(bus.out_col), 72'(q[0].col));
            if (rdy) got.push_back(q.pop_front());
        end
        exp_rdy = !(pend && !rdy);
        acc     = 1'b0;
        if (v) begin
            chk("in_ready", 72'(bus.in_ready), 72'(exp_rdy));
            if (exp_rdy) begin
                acc = 1'b1;
                model_accept(p, s);
            end
        end
    endtask

    task automatic send(input logic [7:0] p, input logic s);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            if (rand_mode && $urandom_range(0, 3) == 0)
                cycle(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), acc);
            else
                cycle(1'b1, p, s, rand_mode ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: pixel %0h not accepted after %0d cycles", p, n);
        end
    endtask

    task automatic drain(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sof    = 1'b1;
        bus.in_pixel  = 8'hAA;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready_now", 72'(bus.in_ready), 72'd0);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 72'(bus.in_ready), 72'd0);
        chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
        chk("rst_taps", dut_taps(), 72'd0);
        chk("rst_row_col", 72'({bus.out_row, bus.out_col}), 72'd0);
        chk("rst_pulses", 72'({bus.frame_done, bus.frame_err}), 72'd0);
        q.delete();
        m_active = 1'b0;
        m_r      = 0;
        m_c      = 0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        @(negedge clk);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic frame_section(input int base, input int from_idx, input int to_idx, input bit sof_first);
        for (int idx = from_idx; idx <= to_idx; idx++)
            send(pix(base, idx / W, idx % W), sof_first && (idx == from_idx));
    endtask

    initial begin
        int n0, d0;
        logic acc;
        //          rst   v     s     p      rdy   e_ir  e_ov
        tbl[0] = '{1'b1, 1'b1, 1'b1, 8'd5,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'd5,  1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'd99, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'd99, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8'd99, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 1'b1, 1'b0};

        reset = 1'b1; bus.in_valid = 1'b0; bus.in_pixel = 8'h00; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state and drop-before-sof behaviour.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            reset = tbl[i].rst; bus.in_valid = tbl[i].v; bus.in_sof = tbl[i].s;
            bus.in_pixel = tbl[i].p; bus.out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 72'(bus.in_ready), 72'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 72'(bus.out_valid), 72'(tbl[i].e_ov));
            chk($sformatf("vec%0d_taps", i), dut_taps(), 72'd0);
        end
        reset = 1'b0;

        // Full frame, pixel = r*5+c.
        n0 = got.size(); d0 = done_seen;
        frame_section(0, 0, W * H - 1, 1'b1);
        drain(3);
        chk("t1_windows", 72'(got.size() - n0), 72'd6);
        chk("t1_done", 72'(done_seen - d0), 72'd1);
        if (got.size() == n0 + 6) begin
            chk("t1_first_taps", got[n0].taps, 72'h00_01_02_05_06_07_0a_0b_0c);
            chk("t1_first_centre", 72'({got[n0].row, got[n0].col}), 72'({2'd1, 3'd1}));
            chk("t1_last_centre", 72'({got[n0+5].row, got[n0+5].col}), 72'({2'd2, 3'd3}));
        end

        // Downstream stall on window 2 for four cycles.
        n0 = got.size();
        frame_section(0, 0, 13, 1'b1);
        repeat (4) cycle(1'b1, pix(0, 2, 4), 1'b0, 1'b0, acc);
        frame_section(0, 14, W * H - 1, 1'b0);
        drain(3);
        chk("t2_windows", 72'(got.size() - n0), 72'd6);

        // In_sof at (2,1) mid-frame restarts the frame.
        n0 = got.size(); d0 = err_seen;
        frame_section(0, 0, 10, 1'b1);
        frame_section(100, 0, W * H - 1, 1'b1);
        drain(3);
        chk("t4_err", 72'(err_seen - d0), 72'd1);
        chk("t4_windows", 72'(got.size() - n0), 72'd6);

        // Reset at pixel (3,2) with a window pending, then a clean frame.
        frame_section(50, 0, 17, 1'b1);
        do_reset();
        n0 = got.size(); d0 = done_seen;
        frame_section(0, 0, W * H - 1, 1'b1);
        drain(3);
        chk("t5_windows", 72'(got.size() - n0), 72'd6);
        chk("t5_done", 72'(done_seen - d0), 72'd1);

        // Random flow control, three back-to-back frames.
        rand_mode = 1'b1;
        n0 = got.size(); d0 = done_seen;
        for (int f = 0; f < 3; f++) frame_section(f * 37 + 3, 0, W * H - 1, 1'b1);
        rand_mode = 1'b0;
        drain(5);
        chk("t6_windows", 72'(got.size() - n0), 72'd18);
        chk("t6_done", 72'(done_seen - d0), 72'd3);
        chk("t6_queue_empty", 72'(q.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
